// File: rtl/fifo_write_arbiter.sv
// Merges several requesters' FIFO entries into one write port.
// Each requester has a 2-deep skid buffer. Lowest index wins, except that a requester starved for AgeLimit arbitrations takes priority.
module fifo_write_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned WidthBits = 3,
  parameter int unsigned AgeLimit  = 8
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  input  logic [NumReq-1:0]                                req_valid_i,
  input  logic [NumReq*DataWidth-1:0]                      req_data_i,
  input  logic [NumReq*WidthBits-1:0]                      req_width_i,
  output logic [NumReq-1:0]                                req_ready_o,
  input  logic                                             fifo_full_i,
  output logic                                             write_enable,
  output logic [DataWidth-1:0]                             write_data,
  output logic [WidthBits-1:0]                             write_width,
  output logic [((NumReq > 1) ? $clog2(NumReq) : 1)-1:0]   grant_id_o,
  output logic                                             width_err_o
);

  localparam int unsigned IdW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned AgeW     = (AgeLimit > 0) ? $clog2(AgeLimit + 1) : 1;
  localparam int unsigned MaxBytes = DataWidth / 8;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [WidthBits-1:0] width;
  } entry_t;

  entry_t               in_entry [NumReq];
  logic [NumReq-1:0]    in_legal;
  logic [NumReq-1:0]    accept;
  logic [NumReq-1:0]    push;
  logic [NumReq-1:0]    pop;
  logic [NumReq-1:0]    nonempty;
  logic [NumReq-1:0]    urgent;
  logic                 any_urgent;
  logic                 win_found;
  logic [IdW-1:0]       win_idx;
  entry_t               win_entry;

  entry_t               head_q  [NumReq];
  entry_t               head_d  [NumReq];
  entry_t               tail_q  [NumReq];
  entry_t               tail_d  [NumReq];
  logic [1:0]           count_q [NumReq];
  logic [1:0]           count_d [NumReq];
  logic [AgeW-1:0]      age_q   [NumReq];
  logic [AgeW-1:0]      age_d   [NumReq];

  logic                 write_enable_q, write_enable_d;
  logic [DataWidth-1:0] write_data_q,   write_data_d;
  logic [WidthBits-1:0] write_width_q,  write_width_d;
  logic [IdW-1:0]       grant_id_q,     grant_id_d;
  logic                 width_err_q,    width_err_d;

  // Unpack requester lanes; ready depends only on registered occupancy.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      in_entry[i].data  = req_data_i[i*DataWidth +: DataWidth];
      in_entry[i].width = req_width_i[i*WidthBits +: WidthBits];
      in_legal[i]       = (in_entry[i].width != '0) &&
                          (32'(in_entry[i].width) <= MaxBytes);
      req_ready_o[i]    = (count_q[i] != 2'd2);
      accept[i]         = req_valid_i[i] && req_ready_o[i];
      push[i]           = accept[i] && in_legal[i];
      nonempty[i]       = (count_q[i] != 2'd0);
      urgent[i]         = (age_q[i] == AgeW'(AgeLimit));
    end
  end

  // Pick the lowest-index urgent requester, or the lowest-index requester if none is urgent.
  always_comb begin
    any_urgent = |(nonempty & urgent);
    win_found  = 1'b0;
    win_idx    = '0;
    win_entry  = '0;
    pop        = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!win_found && nonempty[i] && (urgent[i] || !any_urgent)) begin
        win_found = 1'b1;
        win_idx   = IdW'(i);
        win_entry = head_q[i];
        pop[i]    = !fifo_full_i;
      end
    end
  end

  // Two-slot buffer: head is always the oldest entry.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      head_d[i]  = head_q[i];
      tail_d[i]  = tail_q[i];
      count_d[i] = count_q[i];
      case (count_q[i])
        2'd0: begin
          if (push[i]) begin
            head_d[i]  = in_entry[i];
            count_d[i] = 2'd1;
          end
        end
        2'd1: begin
          if (push[i] && pop[i]) begin
            head_d[i] = in_entry[i];
          end else if (pop[i]) begin
            count_d[i] = 2'd0;
          end else if (push[i]) begin
            tail_d[i]  = in_entry[i];
            count_d[i] = 2'd2;
          end
        end
        default: begin
          if (pop[i]) begin
            head_d[i]  = tail_q[i];
            count_d[i] = 2'd1;
          end
        end
      endcase
    end
  end

  // Starvation counters freeze while the downstream FIFO is full.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      age_d[i] = age_q[i];
      if (!fifo_full_i) begin
        if (!nonempty[i] || pop[i]) begin
          age_d[i] = '0;
        end else if (age_q[i] < AgeW'(AgeLimit)) begin
          age_d[i] = age_q[i] + AgeW'(1);
        end
      end
    end
  end

  always_comb begin
    write_enable_d = |pop;
    write_data_d   = write_data_q;
    write_width_d  = write_width_q;
    grant_id_d     = grant_id_q;
    width_err_d    = width_err_q | (|(accept & ~in_legal));
    if (|pop) begin
      write_data_d  = win_entry.data;
      write_width_d = win_entry.width;
      grant_id_d    = win_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < NumReq; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= 2'd0;
        age_q[i]   <= '0;
      end
      write_enable_q <= 1'b0;
      write_data_q   <= '0;
      write_width_q  <= '0;
      grant_id_q     <= '0;
      width_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        head_q[i]  <= head_d[i];
        tail_q[i]  <= tail_d[i];
        count_q[i] <= count_d[i];
        age_q[i]   <= age_d[i];
      end
      write_enable_q <= write_enable_d;
      write_data_q   <= write_data_d;
      write_width_q  <= write_width_d;
      grant_id_q     <= grant_id_d;
      width_err_q    <= width_err_d;
    end
  end

  assign write_enable = write_enable_q;
  assign write_data   = write_data_q;
  assign write_width  = write_width_q;
  assign grant_id_o   = grant_id_q;
  assign width_err_o  = width_err_q;

endmodule
